mem_stage_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle memory stage.
- Owns the data memory, performs byte, half and word loads/stores with sign/zero extension, and inserts configurable wait states with a stall handshake to the hazard unit.
- Contains the M->W pipeline register.
- Sits between the execute/M register and writeback; forwards ALU result and destination register combinationally to hazard/forwarding logic.

---
 rtl/mem_stage_mc_if.sv | 44 ++++
 rtl/mem_stage_mc.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage_mc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_mc_if.sv
// Bus between the execute/M register, the hazard unit and writeback for the
// multi-cycle memory stage. The master drives the M-stage fields and
// observes the stall, forwarding and W-register outputs. The slave is
// mem_stage_mc itself.
interface mem_stage_mc_if;
  // M-stage inputs
  logic        RegWriteM;
  logic        MemToRegM;
  logic        MemWriteM;
  logic [1:0]  MemSizeM;
  logic        MemSignedM;
  logic        SyscallM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;

  // Hazard / forwarding outputs
  logic        StallM;
  logic [31:0] ALUOut_forwarded;
  logic [4:0]  WriteRegM_hazard;

  // M->W pipeline register outputs
  logic        RegWriteW;
  logic        MemtoRegW;
  logic        SyscallW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic        AddrErrW;

  modport master (
    output RegWriteM, MemToRegM, MemWriteM, MemSizeM, MemSignedM, SyscallM,
           ALUOutM, WriteDataM, WriteRegM,
    input  StallM, ALUOut_forwarded, WriteRegM_hazard,
           RegWriteW, MemtoRegW, SyscallW, ReadDataW, ALUOutW, WriteRegW, AddrErrW
  );

  modport slave (
    input  RegWriteM, MemToRegM, MemWriteM, MemSizeM, MemSignedM, SyscallM,
           ALUOutM, WriteDataM, WriteRegM,
    output StallM, ALUOut_forwarded, WriteRegM_hazard,
           RegWriteW, MemtoRegW, SyscallW, ReadDataW, ALUOutW, WriteRegW, AddrErrW
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage with the data memory and the M->W register.
// Byte, half and word loads/stores with sign/zero extension. Each memory
// access takes 1+WAIT_CYCLES cycles, and StallM is held high for
// WAIT_CYCLES of them. Non-access instructions pass through in one cycle.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses raise AddrErrW and suppress the write. When it is
// undefined, AddrErrW stays 0 and the low address bits are ignored.
module mem_stage_mc #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_mc_if.slave  bus
);

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  // The counter only ever holds values up to WAIT_CYCLES-1.
  localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;

  logic               access;
  logic               stall_raw;
  logic               complete;
  logic               misaligned;
  logic [ADDR_W-1:0]  word_idx;
  logic [1:0]         byte_off;
  logic [3:0]         byte_en;
  logic [31:0]        st_data;
  logic               mem_we;
  logic [31:0]        rd_word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_ext;

  assign access   = bus.MemToRegM | bus.MemWriteM;
  assign word_idx = bus.ALUOutM[ADDR_W+1:2];
  assign byte_off = bus.ALUOutM[1:0];

  // Forwarding paths to the hazard unit are purely combinational.
  assign bus.ALUOut_forwarded = bus.ALUOutM;
  assign bus.WriteRegM_hazard = bus.WriteRegM;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = access &
                      (((bus.MemSizeM == 2'b01) & byte_off[0]) |
                       (bus.MemSizeM[1] & (byte_off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Stall covers the first IDLE cycle of an access and every BUSY cycle.
  always_comb begin
    stall_raw = 1'b0;
    case (state_reg)
      IDLE:    stall_raw = access & HAS_WAIT;
      BUSY:    stall_raw = 1'b1;
      default: stall_raw = 1'b0;
    endcase
  end

  // While reset is asserted, the stall is forced low so the upstream stages are released.
  assign bus.StallM = stall_raw & ~reset;
  assign complete   = ~stall_raw;

  // Sequencer. The counter holds the number of stall cycles still to come.
  // The IDLE cycle uses up one of them, so BUSY runs for WAIT_CYCLES-1 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access && HAS_WAIT) begin
            wait_cnt_reg <= CNT_W'(WAIT_CYCLES - 1);
            state_reg    <= (WAIT_CYCLES == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          wait_cnt_reg <= wait_cnt_reg - 1'b1;
          if (wait_cnt_reg == CNT_W'(1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane enables. The store data is replicated across lanes, so each
  // lane only needs its enable.
  always_comb begin
    byte_en = 4'b1111;
    st_data = bus.WriteDataM;
    case (bus.MemSizeM)
      2'b00: begin
        byte_en = 4'b0001 << byte_off;
        st_data = {4{bus.WriteDataM[7:0]}};
      end
      2'b01: begin
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.WriteDataM[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        st_data = bus.WriteDataM;
      end
    endcase
  end

  // A store commits only on its completion edge, so an aborted access leaves memory untouched.
  assign mem_we = complete & bus.MemWriteM & ~misaligned;

  // Four byte-wide memories. With wait states, the read is registered. The
  // address is stable for at least one edge before completion, so the
  // registered word is the contents before the write (read-before-write).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Lane write on the completion edge of a store.
      always_ff @(posedge clk) begin
        if (mem_we && byte_en[gi]) begin
          lane_mem[word_idx] <= st_data[gi*8 +: 8];
        end
      end

      if (HAS_WAIT) begin : g_rd_reg
        logic [7:0] rd_lane_reg;

        // Registered lane read, updated every cycle.
        always_ff @(posedge clk) begin
          rd_lane_reg <= lane_mem[word_idx];
        end

        assign rd_word[gi*8 +: 8] = rd_lane_reg;
      end else begin : g_rd_async
        assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
      end
    end
  endgenerate

  // Lane selection and sign/zero extension of the loaded data.
  always_comb begin
    byte_sel = rd_word[7:0];
    case (byte_off)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.MemSizeM)
      2'b00:   load_ext = {{24{bus.MemSignedM & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{bus.MemSignedM & half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
  end

  // M->W register. It loads the instruction on completion and a bubble
  // while stalled. A trapped access is handed to W as a non-writing entry
  // that carries AddrErrW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.RegWriteW <= 1'b0;
      bus.MemtoRegW <= 1'b0;
      bus.SyscallW  <= 1'b0;
      bus.AddrErrW  <= 1'b0;
      bus.ReadDataW <= '0;
      bus.ALUOutW   <= '0;
      bus.WriteRegW <= '0;
    end else if (complete) begin
      bus.RegWriteW <= bus.RegWriteM & ~misaligned;
      bus.MemtoRegW <= bus.MemToRegM & ~misaligned;
      bus.SyscallW  <= bus.SyscallM;
      bus.AddrErrW  <= misaligned;
      bus.ReadDataW <= load_ext;
      bus.ALUOutW   <= bus.ALUOutM;
      bus.WriteRegW <= bus.WriteRegM;
    end else begin
      bus.RegWriteW <= 1'b0;
      bus.MemtoRegW <= 1'b0;
      bus.SyscallW  <= 1'b0;
      bus.AddrErrW  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed testbench for mem_stage_mc with the default parameters
// (DEPTH=1024, WAIT_CYCLES=2).
module tb_mem_stage_mc;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] rd;

  mem_stage_mc_if bus ();

  mem_stage_mc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.RegWriteM  = 1'b0;
    bus.MemToRegM  = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.MemSizeM   = 2'b10;
    bus.MemSignedM = 1'b0;
    bus.SyscallM   = 1'b0;
    bus.ALUOutM    = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.WriteRegM  = 5'd0;
  endtask

  // Called at posedge+1. Drives one instruction, counts its stall cycles,
  // checks a bubble after each stall edge, then returns at posedge+1 after
  // the completion edge with the inputs back to idle.
  task automatic run_op(input string name, input logic rw, input logic mtr, input logic mw,
                        input logic [1:0] sz, input logic sgn, input logic sc,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr,
                        input int exp_stall);
    int n;
    bus.RegWriteM  = rw;
    bus.MemToRegM  = mtr;
    bus.MemWriteM  = mw;
    bus.MemSizeM   = sz;
    bus.MemSignedM = sgn;
    bus.SyscallM   = sc;
    bus.ALUOutM    = addr;
    bus.WriteDataM = wd;
    bus.WriteRegM  = wr;
    #1;
    check({name, "_fwd"}, bus.ALUOut_forwarded, addr);
    check({name, "_hazreg"}, {27'd0, bus.WriteRegM_hazard}, {27'd0, wr});
    n = 0;
    while (bus.StallM === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
      check({name, "_bubble"}, {31'd0, bus.RegWriteW}, 32'd0);
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    @(posedge clk);
    #1;
    set_idle();
    $display("op %s addr=%h wd=%h rd=%h rw=%b stall=%0d", name, addr, wd, bus.ReadDataW,
             bus.RegWriteW, n);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    // Reset state
    check("rst_stall", {31'd0, bus.StallM}, 32'd0);
    check("rst_regwrite", {31'd0, bus.RegWriteW}, 32'd0);
    check("rst_readdata", bus.ReadDataW, 32'd0);
    check("rst_aluout", bus.ALUOutW, 32'd0);
    check("rst_addrerr", {31'd0, bus.AddrErrW}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Non-access instruction: no stall, W updates on the next edge
    run_op("add", 1, 0, 0, 2'b10, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 0);
    check("add_regwrite", {31'd0, bus.RegWriteW}, 32'd1);
    check("add_memtoreg", {31'd0, bus.MemtoRegW}, 32'd0);
    check("add_syscall", {31'd0, bus.SyscallW}, 32'd1);
    check("add_aluout", bus.ALUOutW, 32'h0000_1234);
    check("add_writereg", {27'd0, bus.WriteRegW}, 32'd5);

    // Word store then load
    run_op("sw10", 0, 0, 1, 2'b10, 0, 0, 32'h10, 32'h1234_5678, 5'd0, 2);
    check("sw10_regwrite", {31'd0, bus.RegWriteW}, 32'd0);
    run_op("lw10", 1, 1, 0, 2'b10, 0, 0, 32'h10, 32'h0, 5'd8, 2);
    check("lw10_data", bus.ReadDataW, 32'h1234_5678);
    check("lw10_regwrite", {31'd0, bus.RegWriteW}, 32'd1);
    check("lw10_memtoreg", {31'd0, bus.MemtoRegW}, 32'd1);
    check("lw10_writereg", {27'd0, bus.WriteRegW}, 32'd8);

    // Byte store; only WriteDataM[7:0] lands in lane 3
    run_op("sb13", 0, 0, 1, 2'b00, 0, 0, 32'h13, 32'hAAAA_AA80, 5'd0, 2);
    run_op("lb13", 1, 1, 0, 2'b00, 1, 0, 32'h13, 32'h0, 5'd9, 2);
    check("lb13_data", bus.ReadDataW, 32'hFFFF_FF80);
    run_op("lbu13", 1, 1, 0, 2'b00, 0, 0, 32'h13, 32'h0, 5'd9, 2);
    check("lbu13_data", bus.ReadDataW, 32'h0000_0080);
    run_op("lw10b", 1, 1, 0, 2'b10, 0, 0, 32'h10, 32'h0, 5'd9, 2);
    check("lw10b_data", bus.ReadDataW, 32'h8034_5678);

    // Half store into the upper lane; the lower lanes must survive
    run_op("sw20", 0, 0, 1, 2'b10, 0, 0, 32'h20, 32'h0, 5'd0, 2);
    run_op("sh22", 0, 0, 1, 2'b01, 0, 0, 32'h22, 32'h5555_BEEF, 5'd0, 2);
    run_op("lh22", 1, 1, 0, 2'b01, 1, 0, 32'h22, 32'h0, 5'd10, 2);
    check("lh22_data", bus.ReadDataW, 32'hFFFF_BEEF);
    run_op("lhu22", 1, 1, 0, 2'b01, 0, 0, 32'h22, 32'h0, 5'd10, 2);
    check("lhu22_data", bus.ReadDataW, 32'h0000_BEEF);
    run_op("lhu_alias", 1, 1, 0, 2'b01, 0, 0, 32'h22 + 32'd4096, 32'h0, 5'd10, 2);
    check("lhu_alias_data", bus.ReadDataW, 32'h0000_BEEF);
    run_op("lw20", 1, 1, 0, 2'b10, 0, 0, 32'h20, 32'h0, 5'd10, 2);
    check("lw20_data", bus.ReadDataW, 32'hBEEF_0000);

    // Load and store together: the old word is returned and the new word is written
    run_op("rbw10", 1, 1, 1, 2'b10, 0, 0, 32'h10, 32'hCAFE_F00D, 5'd11, 2);
    check("rbw10_old", bus.ReadDataW, 32'h8034_5678);
    run_op("lw10c", 1, 1, 0, 2'b10, 0, 0, 32'h10, 32'h0, 5'd11, 2);
    check("lw10c_new", bus.ReadDataW, 32'hCAFE_F00D);

    // Reset in the middle of a store: the store is dropped
    run_op("sw40", 0, 0, 1, 2'b10, 0, 0, 32'h40, 32'h1122_3344, 5'd0, 2);
    run_op("lw40", 1, 1, 0, 2'b10, 0, 0, 32'h40, 32'h0, 5'd12, 2);
    check("lw40_data", bus.ReadDataW, 32'h1122_3344);
    bus.MemWriteM  = 1'b1;
    bus.MemSizeM   = 2'b10;
    bus.ALUOutM    = 32'h40;
    bus.WriteDataM = 32'hDEAD_BEEF;
    #1;
    check("abort_stall_pre", {31'd0, bus.StallM}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_stall", {31'd0, bus.StallM}, 32'd0);
    check("abort_readdata", bus.ReadDataW, 32'd0);
    check("abort_aluout", bus.ALUOutW, 32'd0);
    check("abort_writereg", {27'd0, bus.WriteRegW}, 32'd0);
    set_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op("lw40r", 1, 1, 0, 2'b10, 0, 0, 32'h40, 32'h0, 5'd13, 2);
    check("lw40r_data", bus.ReadDataW, 32'h1122_3344);

    // Misaligned word store and load
    run_op("sw41", 0, 0, 1, 2'b10, 0, 0, 32'h41, 32'h9988_7766, 5'd0, 2);
    check("sw41_regwrite", {31'd0, bus.RegWriteW}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("sw41_addrerr", {31'd0, bus.AddrErrW}, 32'd1);
`else
    check("sw41_addrerr", {31'd0, bus.AddrErrW}, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("sw41_addrerr_clr", {31'd0, bus.AddrErrW}, 32'd0);
    run_op("lw42", 1, 1, 0, 2'b10, 0, 0, 32'h42, 32'h0, 5'd14, 2);
`ifdef MISALIGN_TRAP_EN
    check("lw42_regwrite", {31'd0, bus.RegWriteW}, 32'd0);
    check("lw42_addrerr", {31'd0, bus.AddrErrW}, 32'd1);
`else
    check("lw42_regwrite", {31'd0, bus.RegWriteW}, 32'd1);
    check("lw42_data", bus.ReadDataW, 32'h9988_7766);
`endif
    run_op("lw40m", 1, 1, 0, 2'b10, 0, 0, 32'h40, 32'h0, 5'd15, 2);
`ifdef MISALIGN_TRAP_EN
    check("lw40m_data", bus.ReadDataW, 32'h1122_3344);
`else
    check("lw40m_data", bus.ReadDataW, 32'h9988_7766);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
